// File: rtl/mips_instr_encoder.sv
// Streaming MIPS encoder: turns an op request into a 32-bit instruction word and feeds a one-entry output register.
// Optional: define ENC_DELAY_SLOT_PAD_EN to append a NOP after every j/jr.
module mips_instr_encoder #(
   parameter int          ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err_illegal
);

   typedef enum logic [3:0] {
      OP_ADD = 4'd0, OP_AND = 4'd1, OP_ADDI = 4'd2, OP_ANDI = 4'd3,
      OP_J   = 4'd4, OP_JR  = 4'd5, OP_LW   = 4'd6, OP_NOR  = 4'd7,
      OP_OR  = 4'd8, OP_ORI = 4'd9, OP_SLT  = 4'd10, OP_SLTI = 4'd11,
      OP_SW  = 4'd12, OP_SUB = 4'd13, OP_SUBU = 4'd14, OP_ILL = 4'd15
   } op_e;

`ifdef ENC_DELAY_SLOT_PAD_EN
   typedef enum logic {IDLE = 1'b0, PAD = 1'b1} state_e;
`else
   typedef enum logic {IDLE = 1'b0} state_e;
`endif

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   state_e              state_q, state_d;
   logic                out_valid_q, out_valid_d;
   logic [31:0]         out_instr_q, out_instr_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
   logic                err_q, err_d;

   logic [31:0]         word;
   logic                illegal;
   logic                accept;
   logic                consume;
`ifdef ENC_DELAY_SLOT_PAD_EN
   logic                is_jump;
`endif

   // Only the fields an op actually uses reach the word.
   always_comb begin
      word    = 32'h0;
      illegal = 1'b0;
      case (op_e'(in_op))
         OP_ADD:  word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h20};
         OP_AND:  word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h24};
         OP_NOR:  word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h27};
         OP_OR:   word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h25};
         OP_SLT:  word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h2a};
         OP_SUB:  word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h22};
         OP_SUBU: word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h23};
         OP_JR:   word = {6'h00, in_rs, 15'b0, 6'h08};
         OP_ADDI: word = {6'h08, in_rs, in_rt, in_imm};
         OP_ANDI: word = {6'h0c, in_rs, in_rt, in_imm};
         OP_LW:   word = {6'h23, in_rs, in_rt, in_imm};
         OP_ORI:  word = {6'h0d, in_rs, in_rt, in_imm};
         OP_SLTI: word = {6'h0a, in_rs, in_rt, in_imm};
         OP_SW:   word = {6'h2b, in_rs, in_rt, in_imm};
         OP_J:    word = {6'h02, in_target};
         default: illegal = 1'b1;
      endcase
   end

`ifdef ENC_DELAY_SLOT_PAD_EN
   assign is_jump = (in_op == OP_J) || (in_op == OP_JR);
`endif

   assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid_q && out_ready;

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_addr_d  = out_addr_q;
      next_addr_d = next_addr_q;
      err_d       = 1'b0;

      if (consume) out_valid_d = 1'b0;

`ifdef ENC_DELAY_SLOT_PAD_EN
      // Delay-slot NOP goes in once the jump word has left the register.
      if (state_q == PAD && consume) begin
         out_valid_d = 1'b1;
         out_instr_d = 32'h0;
         out_addr_d  = next_addr_q;
         next_addr_d = next_addr_q + ADDR_W'(4);
         state_d     = IDLE;
      end
`endif

      if (accept) begin
         if (illegal) begin
            err_d = 1'b1;
         end else begin
            out_valid_d = 1'b1;
            out_instr_d = word;
            out_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + ADDR_W'(4);
`ifdef ENC_DELAY_SLOT_PAD_EN
            if (is_jump) state_d = PAD;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_instr_q <= 32'h0;
         out_addr_q  <= BASE;
         next_addr_q <= BASE;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_addr_q  <= out_addr_d;
         next_addr_q <= next_addr_d;
         err_q       <= err_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_instr   = out_instr_q;
   assign out_addr    = out_addr_q;
   assign err_illegal = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: default-geometry DUT plus a 4-bit-address DUT (base 0xC) fed the same stream.
module tb_mips_instr_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [3:0]  in_op;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        out_ready;

   logic        in_ready, out_valid, err_illegal;
   logic [31:0] out_instr;
   logic [9:0]  out_addr;

   logic        w_in_ready, w_out_valid, w_err_illegal;
   logic [31:0] w_out_instr;
   logic [3:0]  w_out_addr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mips_instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
      .err_illegal(err_illegal));

   mips_instr_encoder #(.ADDR_W(4), .BASE_ADDR(12)) dut_w (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_imm(in_imm), .in_target(in_target), .out_valid(w_out_valid),
      .out_ready(out_ready), .out_instr(w_out_instr), .out_addr(w_out_addr),
      .err_illegal(w_err_illegal));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change on the falling edge; the DUT samples them on the next rising edge.
   task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
      in_valid  = 1'b1;
      in_op     = op;
      in_rs     = rs;
      in_rt     = rt;
      in_rd     = rd;
      in_imm    = imm;
      in_target = tgt;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_op = 4'd0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_in();
      out_ready = 1'b0;
      @(negedge clk);
      chk("rst_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_addr", {22'b0, out_addr}, 32'h0);
      chk("rst_err", {31'b0, err_illegal}, 32'h0);
      chk("rst_w_addr", {28'b0, w_out_addr}, 32'hC);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_in();
      out_ready = 1'b0;

      // add / addi / lw back to back
      do_reset();
      out_ready = 1'b1;
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF);
      @(negedge clk);
      chk("add_valid", {31'b0, out_valid}, 32'h1);
      chk("add_instr", out_instr, 32'h00221820);
      chk("add_addr", {22'b0, out_addr}, 32'h000);
      send(4'd2, 5'd1, 5'd2, 5'd31, 16'h0005, 26'h3FFFFFF);
      @(negedge clk);
      chk("addi_instr", out_instr, 32'h20220005);
      chk("addi_addr", {22'b0, out_addr}, 32'h004);
      chk("addi_ready", {31'b0, in_ready}, 32'h1);
      send(4'd6, 5'd29, 5'd4, 5'd0, 16'h0008, 26'h0);
      @(negedge clk);
      chk("lw_instr", out_instr, 32'h8FA40008);
      chk("lw_addr", {22'b0, out_addr}, 32'h008);
      chk("lw_ready", {31'b0, in_ready}, 32'h1);
      send(4'd11, 5'd3, 5'd7, 5'd9, 16'h8001, 26'h0);
      @(negedge clk);
      chk("slti_instr", out_instr, 32'h28678001);
      idle_in();
      @(negedge clk);
      chk("drain_valid", {31'b0, out_valid}, 32'h0);

      // j then jr, junk in unused fields
      do_reset();
      out_ready = 1'b1;
      send(4'd4, 5'd7, 5'd7, 5'd7, 16'hABCD, 26'h0000100);
      @(negedge clk);
      chk("j_instr", out_instr, 32'h08000100);
      chk("j_addr", {22'b0, out_addr}, 32'h000);
      send(4'd5, 5'd31, 5'd5, 5'd6, 16'h1234, 26'h2AAAAAA);
`ifdef ENC_DELAY_SLOT_PAD_EN
      chk("pad_ready", {31'b0, in_ready}, 32'h0);
      @(negedge clk);
      chk("pad1_instr", out_instr, 32'h00000000);
      chk("pad1_addr", {22'b0, out_addr}, 32'h004);
      chk("pad1_valid", {31'b0, out_valid}, 32'h1);
      @(negedge clk);
      chk("jr_instr", out_instr, 32'h03E00008);
      chk("jr_addr", {22'b0, out_addr}, 32'h008);
      chk("pad2_ready", {31'b0, in_ready}, 32'h0);
      idle_in();
      @(negedge clk);
      chk("pad2_instr", out_instr, 32'h00000000);
      chk("pad2_addr", {22'b0, out_addr}, 32'h00C);
`else
      @(negedge clk);
      chk("jr_instr", out_instr, 32'h03E00008);
      chk("jr_addr", {22'b0, out_addr}, 32'h004);
      idle_in();
`endif
      @(negedge clk);
      chk("jdrain_valid", {31'b0, out_valid}, 32'h0);

      // backpressure: hold for 5 cycles, then the queued request lands
      do_reset();
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      @(negedge clk);
      send(4'd8, 5'd5, 5'd6, 5'd7, 16'hFFFF, 26'h0);
      for (int i = 0; i < 5; i++) begin
         chk("bp_instr", out_instr, 32'h00221820);
         chk("bp_addr", {22'b0, out_addr}, 32'h000);
         chk("bp_valid", {31'b0, out_valid}, 32'h1);
         chk("bp_ready", {31'b0, in_ready}, 32'h0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_ready_comb", {31'b0, in_ready}, 32'h1);
      @(negedge clk);
      chk("or_instr", out_instr, 32'h00A63825);
      chk("or_addr", {22'b0, out_addr}, 32'h004);
      chk("or_valid", {31'b0, out_valid}, 32'h1);
      idle_in();
      @(negedge clk);
      chk("or_drain", {31'b0, out_valid}, 32'h0);

      // illegal op: pulse, no word, address not advanced
      do_reset();
      out_ready = 1'b1;
      send(4'd15, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
      @(negedge clk);
      chk("ill_err", {31'b0, err_illegal}, 32'h1);
      chk("ill_valid", {31'b0, out_valid}, 32'h0);
      idle_in();
      @(negedge clk);
      chk("ill_err_off", {31'b0, err_illegal}, 32'h0);
      send(4'd13, 5'd8, 5'd9, 5'd10, 16'h0, 26'h0);
      @(negedge clk);
      chk("sub_instr", out_instr, 32'h01095022);
      chk("sub_addr", {22'b0, out_addr}, 32'h000);
      send(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
      @(negedge clk);
      chk("ill2_valid", {31'b0, out_valid}, 32'h0);
      chk("ill2_err", {31'b0, err_illegal}, 32'h1);
      send(4'd12, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0);
      @(negedge clk);
      chk("sw_instr", out_instr, 32'hAC430010);
      chk("sw_addr", {22'b0, out_addr}, 32'h004);
      chk("sw_err_off", {31'b0, err_illegal}, 32'h0);
      idle_in();

      // narrow address: wrap past 0xC, then reset while a word is held
      do_reset();
      out_ready = 1'b1;
      send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      @(negedge clk);
      chk("w1_addr", {28'b0, w_out_addr}, 32'hC);
      chk("w1_instr", w_out_instr, 32'h00221824);
      send(4'd9, 5'd4, 5'd5, 5'd0, 16'h00FF, 26'h0);
      @(negedge clk);
      chk("w2_addr", {28'b0, w_out_addr}, 32'h0);
      chk("w2_instr", w_out_instr, 32'h348500FF);
      idle_in();
      out_ready = 1'b0;
      @(negedge clk);
      chk("w_held", {31'b0, w_out_valid}, 32'h1);
      reset = 1'b1;
      @(negedge clk);
      chk("w_rst_valid", {31'b0, w_out_valid}, 32'h0);
      chk("w_rst_addr", {28'b0, w_out_addr}, 32'hC);
      chk("m_rst_valid", {31'b0, out_valid}, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
